// File: rtl/seq_control_n_if.sv
// Command/status bundle between a controller and the one-hot sequencer.
// master drives the controls and dwell, slave returns the strobes and status.
// No handshake: every signal is sampled or updated on each clock edge.
interface seq_control_n_if #(
    parameter int N_STATES = 6,
    parameter int DWELL_W  = 4,
    parameter int IDX_W    = 3
);
    logic                clr;
    logic                en;
    logic                mode;
    logic                dir;
    logic                start;
    logic [DWELL_W-1:0]  dwell;
    logic [N_STATES-1:0] s;
    logic [IDX_W-1:0]    state_idx;
    logic                done;
    logic                wrap;

    modport master (
        output clr, en, mode, dir, start, dwell,
        input  s, state_idx, done, wrap
    );

    modport slave (
        input  clr, en, mode, dir, start, dwell,
        output s, state_idx, done, wrap
    );
endinterface

// File: rtl/seq_control_n.sv
// One-hot state sequencer with per-state dwell, up/down, wrap or one-shot stop.
// Latency: all outputs registered, one edge after the cause.
// No backpressure: en=0 freezes the sequence; done halts it until start/clr/reset.
module seq_control_n #(
    parameter int N_STATES = 6,
    parameter int DWELL_W  = 4,
    parameter int IDX_W    = 3
) (
    input  logic              clk,
    input  logic              reset,
    seq_control_n_if.slave    bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STATES - 1);

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } phase_t;

    phase_t              phase, phase_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [DWELL_W-1:0]  cnt, cnt_nxt;
    logic [DWELL_W-1:0]  dwell_lat, dwell_lat_nxt;
    logic                wrap_nxt;
    logic                at_end;
    logic [N_STATES-1:0] s_nxt;

    always_comb begin
        phase_nxt     = phase;
        idx_nxt       = idx;
        cnt_nxt       = cnt;
        dwell_lat_nxt = dwell_lat;
        wrap_nxt      = 1'b0;
        // Terminal state depends on the direction sampled at advance time.
        at_end        = bus.dir ? (idx == '0) : (idx == LAST_IDX);

        if (bus.clr) begin
            phase_nxt     = ST_RUN;
            idx_nxt       = '0;
            cnt_nxt       = '0;
            dwell_lat_nxt = bus.dwell;
        end else if (bus.start && phase == ST_HALT) begin
            phase_nxt     = ST_RUN;
            idx_nxt       = bus.dir ? LAST_IDX : '0;
            cnt_nxt       = '0;
            dwell_lat_nxt = bus.dwell;
        end else if (bus.en && phase == ST_RUN) begin
            if (cnt != dwell_lat) begin
                cnt_nxt = cnt + 1'b1;
            end else begin
                cnt_nxt       = '0;
                dwell_lat_nxt = bus.dwell;
                if (at_end && bus.mode) begin
                    // One-shot terminal: stay put and raise done, no wrap pulse.
                    phase_nxt = ST_HALT;
                end else if (at_end) begin
                    wrap_nxt = 1'b1;
                    idx_nxt  = bus.dir ? LAST_IDX : '0;
                end else begin
                    idx_nxt  = bus.dir ? (idx - 1'b1) : (idx + 1'b1);
                end
            end
        end

        s_nxt = '0;
        for (int i = 0; i < N_STATES; i++) begin
            s_nxt[i] = (idx_nxt == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase         <= ST_RUN;
            idx           <= '0;
            cnt           <= '0;
            dwell_lat     <= bus.dwell;
            bus.s         <= N_STATES'(1);
            bus.state_idx <= '0;
            bus.done      <= 1'b0;
            bus.wrap      <= 1'b0;
        end else begin
            phase         <= phase_nxt;
            idx           <= idx_nxt;
            cnt           <= cnt_nxt;
            dwell_lat     <= dwell_lat_nxt;
            bus.s         <= s_nxt;
            bus.state_idx <= idx_nxt;
            bus.done      <= (phase_nxt == ST_HALT);
            bus.wrap      <= wrap_nxt;
        end
    end
endmodule

// File: tb/tb_seq_control_n.sv
// Directed bench for seq_control_n: stimulus queues expected outputs,
// a monitor pops and compares one entry per clock.
module tb_seq_control_n;
    logic clk = 1'b0;
    logic reset;

    seq_control_n_if #(.N_STATES(6), .DWELL_W(4), .IDX_W(3)) bus ();

    seq_control_n #(.N_STATES(6), .DWELL_W(4), .IDX_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   idx;
        logic done;
        logic wrap;
        int   vec;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vec_n    = 0;

    task automatic chk(input string nm, input int vec, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s vec=%0d got=%0h want=%0h", nm, vec, act, req);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must be after the next edge.
    task automatic cyc(input int r, input int c, input int e, input int m, input int d,
                       input int st, input int dw, input int eidx, input int edone, input int ewrap);
        exp_t x;
        @(negedge clk);
        reset     = (r != 0);
        bus.clr   = (c != 0);
        bus.en    = (e != 0);
        bus.mode  = (m != 0);
        bus.dir   = (d != 0);
        bus.start = (st != 0);
        bus.dwell = 4'(dw);
        x.idx  = eidx;
        x.done = (edone != 0);
        x.wrap = (ewrap != 0);
        x.vec  = vec_n;
        vec_n++;
        q.push_back(x);
    endtask

    always begin
        exp_t      mx;
        logic [5:0] es;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            mx = q.pop_front();
            es = 6'b000001 << mx.idx;
            chk("s",         mx.vec, 32'(bus.s),         32'(es));
            chk("state_idx", mx.vec, 32'(bus.state_idx), 32'(mx.idx));
            chk("done",      mx.vec, 32'(bus.done),      32'(mx.done));
            chk("wrap",      mx.vec, 32'(bus.wrap),      32'(mx.wrap));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        bus.clr   = 1'b0;
        bus.en    = 1'b0;
        bus.mode  = 1'b0;
        bus.dir   = 1'b0;
        bus.start = 1'b0;
        bus.dwell = 4'd0;

        // Reset, then one state per clock with wrap pulse on return to S0.
        repeat (2) cyc(1,0,1,0,0,0,0, 0,0,0);
        for (int i = 1; i <= 7; i++) cyc(0,0,1,0,0,0,0, i % 6, 0, (i % 6 == 0) ? 1 : 0);

        // DWELL=2 latched on S2 entry; changing it to 0 mid-S2 only shortens S3.
        cyc(0,0,1,0,0,0,2, 2,0,0);
        cyc(0,0,1,0,0,0,0, 2,0,0);
        cyc(0,0,1,0,0,0,0, 2,0,0);
        cyc(0,0,1,0,0,0,0, 3,0,0);
        cyc(0,0,1,0,0,0,0, 4,0,0);

        // CLR with DWELL=2, walk to S3 with cnt=1.
        cyc(0,1,1,0,0,0,2, 0,0,0);
        repeat (2) cyc(0,0,1,0,0,0,2, 0,0,0);
        repeat (3) cyc(0,0,1,0,0,0,2, 1,0,0);
        repeat (3) cyc(0,0,1,0,0,0,2, 2,0,0);
        repeat (2) cyc(0,0,1,0,0,0,2, 3,0,0);

        // EN=0 freezes state and count; S3 then needs one more enabled cycle.
        repeat (4) cyc(0,0,0,0,0,0,2, 3,0,0);
        cyc(0,0,1,0,0,0,2, 3,0,0);
        cyc(0,0,1,0,0,0,2, 4,0,0);

        // One-shot up: finish S4 dwell, reach S5, then DONE without wrap.
        repeat (2) cyc(0,0,1,1,0,0,0, 4,0,0);
        cyc(0,0,1,1,0,0,0, 5,0,0);
        cyc(0,0,1,1,0,0,0, 5,1,0);
        cyc(0,0,0,1,0,0,0, 5,1,0);
        cyc(0,0,1,1,1,0,0, 5,1,0);
        cyc(0,0,1,1,0,0,0, 5,1,0);
        cyc(0,0,1,1,0,1,0, 0,0,0);

        // Wrap mode down from S0; START ignored while running; CLR beats START.
        cyc(0,0,1,0,1,0,0, 5,0,1);
        cyc(0,0,1,0,1,1,0, 4,0,0);
        cyc(0,0,1,0,1,0,0, 3,0,0);
        cyc(0,1,1,0,1,1,0, 0,0,0);
        cyc(0,0,1,0,1,0,0, 5,0,1);

        // One-shot down to S0 and DONE; START with DIR=1 restarts at S5.
        for (int i = 4; i >= 0; i--) cyc(0,0,1,1,1,0,0, i,0,0);
        cyc(0,0,1,1,1,0,0, 0,1,0);
        cyc(0,0,1,1,1,1,0, 5,0,0);
        for (int i = 4; i >= 0; i--) cyc(0,0,1,1,1,0,0, i,0,0);
        cyc(0,0,1,1,1,0,0, 0,1,0);
        cyc(0,0,1,1,1,0,0, 0,1,0);

        // RESET while DONE; counting resumes after release.
        cyc(1,0,1,1,1,0,0, 0,0,0);
        cyc(0,0,1,0,0,0,0, 1,0,0);
        cyc(0,0,1,0,0,0,0, 2,0,0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
